// File: rtl/io_arbiter.sv
// io_arbiter: round-robin owner of the single byte-wide IO channel shared by port 0 and port 1.
// Define IO_ARB_TIMEOUT_EN to add a WAIT timeout that forces completion and sets a sticky err.
module io_arbiter #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       m0_read_req,
  input  logic       m0_write_req,
  input  logic [7:0] m0_wdata,
  output logic [7:0] m0_rdata,
  output logic       m0_done,
  input  logic       m1_read_req,
  input  logic       m1_write_req,
  input  logic [7:0] m1_wdata,
  output logic [7:0] m1_rdata,
  output logic       m1_done,
  output logic [1:0] grant,
  output logic       io_read_req,
  output logic       io_write_req,
  output logic [7:0] io_wdata,
  input  logic       io_ready,
  input  logic       io_done,
  input  logic [7:0] io_rdata,
  output logic       err
);

  // state  | meaning
  // IDLE   | no owner, sample requests
  // ISSUE  | io request driven, waiting for io_ready
  // WAIT   | io request dropped, waiting for io_done
  // RESP   | owner's done pulse, then release
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t     r_state,  w_state_nxt;
  logic [1:0] r_grant,  w_grant_nxt;
  logic       r_last,   w_last_nxt;
  logic       r_op_wr,  w_op_wr_nxt;
  logic       r_rd_req, w_rd_req_nxt;
  logic       r_wr_req, w_wr_req_nxt;
  logic [7:0] r_wdata,  w_wdata_nxt;
  logic [7:0] r_rdata0, w_rdata0_nxt;
  logic [7:0] r_rdata1, w_rdata1_nxt;
  logic       r_done0,  w_done0_nxt;
  logic       r_done1,  w_done1_nxt;
  logic       r_err,    w_err_nxt;
  logic       w_req0, w_req1, w_pick1, w_op_sel, w_capture, w_tmo;

`ifdef IO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_TMO = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  assign w_req0 = m0_read_req | m0_write_req;
  assign w_req1 = m1_read_req | m1_write_req;
  // r_last = 1 means port 1 was served last, so port 0 wins a tie
  assign w_pick1  = w_req1 & (~w_req0 | ~r_last);
  assign w_op_sel = w_pick1 ? m1_write_req : m0_write_req;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    w_op_wr_nxt  = r_op_wr;
    w_rd_req_nxt = r_rd_req;
    w_wr_req_nxt = r_wr_req;
    w_wdata_nxt  = r_wdata;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    w_done0_nxt  = 1'b0;
    w_done1_nxt  = 1'b0;
    w_err_nxt    = r_err;
    w_capture    = 1'b0;
    w_tmo        = 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
    w_cnt_nxt    = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          w_grant_nxt  = w_pick1 ? 2'b10 : 2'b01;
          w_op_wr_nxt  = w_op_sel;
          w_wr_req_nxt = w_op_sel;
          w_rd_req_nxt = ~w_op_sel;
          w_wdata_nxt  = w_pick1 ? m1_wdata : m0_wdata;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (io_ready) begin
          w_rd_req_nxt = 1'b0;
          w_wr_req_nxt = 1'b0;
          if (io_done) begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
`ifdef IO_ARB_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (io_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
`ifdef IO_ARB_TIMEOUT_EN
        else if (w_cnt_inc == C_TMO) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
`endif
      end
      S_RESP: begin
        w_last_nxt  = r_grant[1];
        w_grant_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_capture | w_tmo) begin
      w_done0_nxt = r_grant[0];
      w_done1_nxt = r_grant[1];
      if (w_tmo) begin
        w_err_nxt = 1'b1;
        if (r_grant[0]) w_rdata0_nxt = 8'h00;
        if (r_grant[1]) w_rdata1_nxt = 8'h00;
      end else if (!r_op_wr) begin
        if (r_grant[0]) w_rdata0_nxt = io_rdata;
        if (r_grant[1]) w_rdata1_nxt = io_rdata;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= S_IDLE;
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_op_wr  <= 1'b0;
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      r_wdata  <= 8'h00;
      r_rdata0 <= 8'h00;
      r_rdata1 <= 8'h00;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_op_wr  <= w_op_wr_nxt;
      r_rd_req <= w_rd_req_nxt;
      r_wr_req <= w_wr_req_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
      r_done0  <= w_done0_nxt;
      r_done1  <= w_done1_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign grant        = r_grant;
  assign io_read_req  = r_rd_req;
  assign io_write_req = r_wr_req;
  assign io_wdata     = r_wdata;
  assign m0_rdata     = r_rdata0;
  assign m1_rdata     = r_rdata1;
  assign m0_done      = r_done0;
  assign m1_done      = r_done1;
  assign err          = r_err;

endmodule
